// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants, the fetch queue entry type and the PC alignment helper
// for the instruction fetch slice.
package pc_fetch_unit_pkg;

    localparam int          XLEN          = 32;
    localparam int          INSTR_BYTES   = 4;
    localparam int          PC_ALIGN_BITS = 2;
    localparam logic [31:0] RESET_VECTOR  = 32'h0000_0000;

    // One queue slot: the instruction word together with the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Clears the byte-offset bits so that a redirect always lands on a word.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:PC_ALIGN_BITS], {PC_ALIGN_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   push_i / wdata_i    write one entry at the write pointer
//   pop_i               retire the head entry
//   flush_i             empty the queue (takes priority over push/pop)
//   head_o              registered head entry
//   count_o             number of valid entries
// A push and a pop in the same cycle are legal while full: the written slot is
// the one being retired, and the head read this cycle still sees the old word.
module fetch_queue
    import pc_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fetch_entry_t  wdata_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is the natural overflow.
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: owns the PC, addresses instr_mem, queues the
// returned words and hands them to decode over valid/ready. Redirects from
// execute flush the queue and reload the PC.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   imem_addr / imem_rdata         instr_mem address (straight from the PC flop)
//                                  and its combinational read data
//   redirect_valid / redirect_pc   PC change request from execute
//   dec_valid / dec_ready          decode handshake
//   dec_instr / dec_pc             queue head entry
//   misaligned_err                 one-cycle pulse for a redirect with pc[1:0]!=0
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        misaligned_err
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          misaligned_q, misaligned_d;
    logic [CW-1:0] count;
    logic          push, pop;
    fetch_entry_t  wr_entry, head;

    // A redirect kills the current head even if decode is ready, so neither
    // push nor pop is allowed in that cycle.
    assign pop  = dec_valid & dec_ready & ~redirect_valid;
    assign push = ~redirect_valid & ((count < CW'(QDEPTH)) | pop);

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        misaligned_d = redirect_valid & (|redirect_pc[PC_ALIGN_BITS-1:0]);
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q   <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign wr_entry.pc    = fetch_pc_q;
    assign wr_entry.instr = imem_rdata;

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wr_entry),
        .head_o  (head),
        .count_o (count)
    );

    assign imem_addr      = fetch_pc_q;
    assign dec_valid      = (count != '0);
    assign dec_instr      = head.instr;
    assign dec_pc         = head.pc;
    assign misaligned_err = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk;
    int          pass_cnt;
    int          total_cnt;

    // Instance 0: default RESET_PC
    logic        rst0;
    logic [31:0] imem_addr0, imem_rdata0;
    logic        redirect_valid0;
    logic [31:0] redirect_pc0;
    logic        dec_valid0, dec_ready0;
    logic [31:0] dec_instr0, dec_pc0;
    logic        misaligned0;

    // Instance 1: RESET_PC near the top of the address space
    logic        rst1;
    logic [31:0] imem_addr1, imem_rdata1;
    logic        redirect_valid1;
    logic [31:0] redirect_pc1;
    logic        dec_valid1, dec_ready1;
    logic [31:0] dec_instr1, dec_pc1;
    logic        misaligned1;

    // instr_mem model: each word is the bitwise inverse of its address.
    assign imem_rdata0 = ~imem_addr0;
    assign imem_rdata1 = ~imem_addr1;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) u_dut0 (
        .clk            (clk),
        .rst            (rst0),
        .imem_addr      (imem_addr0),
        .imem_rdata     (imem_rdata0),
        .redirect_valid (redirect_valid0),
        .redirect_pc    (redirect_pc0),
        .dec_valid      (dec_valid0),
        .dec_ready      (dec_ready0),
        .dec_instr      (dec_instr0),
        .dec_pc         (dec_pc0),
        .misaligned_err (misaligned0)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) u_dut1 (
        .clk            (clk),
        .rst            (rst1),
        .imem_addr      (imem_addr1),
        .imem_rdata     (imem_rdata1),
        .redirect_valid (redirect_valid1),
        .redirect_pc    (redirect_pc1),
        .dec_valid      (dec_valid1),
        .dec_ready      (dec_ready1),
        .dec_instr      (dec_instr1),
        .dec_pc         (dec_pc1),
        .misaligned_err (misaligned1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset0(input logic rdy);
        rst0            = 1'b0;
        redirect_valid0 = 1'b0;
        redirect_pc0    = 32'h0;
        dec_ready0      = rdy;
        tick();
        tick();
        rst0 = 1'b1;
    endtask

    task automatic test_reset();
        rst0 = 1'b0;
        #3;
        total_cnt++;
        if (dec_valid0 !== 1'b0) $display("FAIL reset_dec_valid: got %b expected 0", dec_valid0);
        else pass_cnt++;
        total_cnt++;
        if (imem_addr0 !== 32'h0) $display("FAIL reset_imem_addr: got %h expected 00000000", imem_addr0);
        else pass_cnt++;
        total_cnt++;
        if (dec_pc0 !== 32'h0) $display("FAIL reset_dec_pc: got %h expected 00000000", dec_pc0);
        else pass_cnt++;
        total_cnt++;
        if (dec_instr0 !== 32'h0) $display("FAIL reset_dec_instr: got %h expected 00000000", dec_instr0);
        else pass_cnt++;
        total_cnt++;
        if (misaligned0 !== 1'b0) $display("FAIL reset_misaligned: got %b expected 0", misaligned0);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset0(1'b1);
        total_cnt++;
        if (imem_addr0 !== 32'h0) $display("FAIL stream_first_addr: got %h expected 00000000", imem_addr0);
        else pass_cnt++;
        total_cnt++;
        if (dec_valid0 !== 1'b0) $display("FAIL stream_first_valid: got %b expected 0", dec_valid0);
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_pc = 32'(4 * k);
            total_cnt++;
            if (dec_valid0 !== 1'b1) $display("FAIL stream_valid[%0d]: got %b expected 1", k, dec_valid0);
            else pass_cnt++;
            total_cnt++;
            if (dec_pc0 !== exp_pc) $display("FAIL stream_pc[%0d]: got %h expected %h", k, dec_pc0, exp_pc);
            else pass_cnt++;
            total_cnt++;
            if (dec_instr0 !== ~exp_pc) $display("FAIL stream_instr[%0d]: got %h expected %h", k, dec_instr0, ~exp_pc);
            else pass_cnt++;
            total_cnt++;
            if (imem_addr0 !== exp_pc + 32'd4) $display("FAIL stream_addr[%0d]: got %h expected %h", k, imem_addr0, exp_pc + 32'd4);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        do_reset0(1'b0);
        repeat (5) tick();
        total_cnt++;
        if (imem_addr0 !== 32'h8) $display("FAIL stall_addr: got %h expected 00000008", imem_addr0);
        else pass_cnt++;
        total_cnt++;
        if (dec_valid0 !== 1'b1) $display("FAIL stall_valid: got %b expected 1", dec_valid0);
        else pass_cnt++;
        total_cnt++;
        if (dec_pc0 !== 32'h0) $display("FAIL stall_head_pc: got %h expected 00000000", dec_pc0);
        else pass_cnt++;
        total_cnt++;
        if (dec_instr0 !== 32'hFFFF_FFFF) $display("FAIL stall_head_instr: got %h expected ffffffff", dec_instr0);
        else pass_cnt++;
        dec_ready0 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp_pc = 32'(4 * k);
            total_cnt++;
            if (dec_pc0 !== exp_pc) $display("FAIL stall_drain_pc[%0d]: got %h expected %h", k, dec_pc0, exp_pc);
            else pass_cnt++;
            total_cnt++;
            if (dec_instr0 !== ~exp_pc) $display("FAIL stall_drain_instr[%0d]: got %h expected %h", k, dec_instr0, ~exp_pc);
            else pass_cnt++;
            total_cnt++;
            if (imem_addr0 !== exp_pc + 32'd8) $display("FAIL stall_drain_addr[%0d]: got %h expected %h", k, imem_addr0, exp_pc + 32'd8);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        do_reset0(1'b0);
        tick();
        tick();
        total_cnt++;
        if (imem_addr0 !== 32'h8) $display("FAIL b2b_full_addr: got %h expected 00000008", imem_addr0);
        else pass_cnt++;
        dec_ready0 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_pc = 32'(4 * k);
            total_cnt++;
            if (dec_pc0 !== exp_pc) $display("FAIL b2b_pc[%0d]: got %h expected %h", k, dec_pc0, exp_pc);
            else pass_cnt++;
            total_cnt++;
            if (imem_addr0 !== exp_pc + 32'd8) $display("FAIL b2b_addr[%0d]: got %h expected %h", k, imem_addr0, exp_pc + 32'd8);
            else pass_cnt++;
        end
        // Queue must still be full: with decode stalled the PC may not move.
        dec_ready0 = 1'b0;
        tick();
        total_cnt++;
        if (imem_addr0 !== 32'd24) $display("FAIL b2b_still_full_addr: got %h expected 00000018", imem_addr0);
        else pass_cnt++;
        total_cnt++;
        if (dec_pc0 !== 32'd16) $display("FAIL b2b_still_full_pc: got %h expected 00000010", dec_pc0);
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        // Entered with a full queue (heads 16, 20) from test_back_to_back.
        dec_ready0      = 1'b1;
        redirect_valid0 = 1'b1;
        redirect_pc0    = 32'h100;
        tick();
        redirect_valid0 = 1'b0;
        total_cnt++;
        if (dec_valid0 !== 1'b0) $display("FAIL redirect_flush_valid: got %b expected 0", dec_valid0);
        else pass_cnt++;
        total_cnt++;
        if (imem_addr0 !== 32'h100) $display("FAIL redirect_addr: got %h expected 00000100", imem_addr0);
        else pass_cnt++;
        total_cnt++;
        if (misaligned0 !== 1'b0) $display("FAIL redirect_aligned_err: got %b expected 0", misaligned0);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (dec_valid0 !== 1'b1) $display("FAIL redirect_target_valid: got %b expected 1", dec_valid0);
        else pass_cnt++;
        total_cnt++;
        if (dec_pc0 !== 32'h100) $display("FAIL redirect_target_pc: got %h expected 00000100", dec_pc0);
        else pass_cnt++;
        total_cnt++;
        if (dec_instr0 !== ~32'h100) $display("FAIL redirect_target_instr: got %h expected %h", dec_instr0, ~32'h100);
        else pass_cnt++;
        total_cnt++;
        if (imem_addr0 !== 32'h104) $display("FAIL redirect_next_addr: got %h expected 00000104", imem_addr0);
        else pass_cnt++;
    endtask

    task automatic test_misaligned();
        dec_ready0      = 1'b1;
        redirect_valid0 = 1'b1;
        redirect_pc0    = 32'h102;
        total_cnt++;
        if (misaligned0 !== 1'b0) $display("FAIL misaligned_before: got %b expected 0", misaligned0);
        else pass_cnt++;
        tick();
        redirect_valid0 = 1'b0;
        total_cnt++;
        if (misaligned0 !== 1'b1) $display("FAIL misaligned_pulse: got %b expected 1", misaligned0);
        else pass_cnt++;
        total_cnt++;
        if (imem_addr0 !== 32'h100) $display("FAIL misaligned_addr: got %h expected 00000100", imem_addr0);
        else pass_cnt++;
        total_cnt++;
        if (dec_valid0 !== 1'b0) $display("FAIL misaligned_flush_valid: got %b expected 0", dec_valid0);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (misaligned0 !== 1'b0) $display("FAIL misaligned_one_cycle: got %b expected 0", misaligned0);
        else pass_cnt++;
        total_cnt++;
        if (dec_pc0 !== 32'h100) $display("FAIL misaligned_target_pc: got %h expected 00000100", dec_pc0);
        else pass_cnt++;
    endtask

    task automatic test_wrap_and_async_reset();
        logic [31:0] seq [4];
        seq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        dec_ready1 = 1'b1;
        tick();
        rst1 = 1'b1;
        total_cnt++;
        if (imem_addr1 !== 32'hFFFF_FFF8) $display("FAIL wrap_reset_addr: got %h expected fffffff8", imem_addr1);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if (dec_pc1 !== seq[k]) $display("FAIL wrap_pc[%0d]: got %h expected %h", k, dec_pc1, seq[k]);
            else pass_cnt++;
            total_cnt++;
            if (dec_instr1 !== ~seq[k]) $display("FAIL wrap_instr[%0d]: got %h expected %h", k, dec_instr1, ~seq[k]);
            else pass_cnt++;
            total_cnt++;
            if (imem_addr1 !== seq[k+1]) $display("FAIL wrap_addr[%0d]: got %h expected %h", k, imem_addr1, seq[k+1]);
            else pass_cnt++;
        end
        // Mid-cycle reset: effect must be visible before the next clock edge.
        #2;
        rst1 = 1'b0;
        #1;
        total_cnt++;
        if (dec_valid1 !== 1'b0) $display("FAIL async_reset_valid: got %b expected 0", dec_valid1);
        else pass_cnt++;
        total_cnt++;
        if (imem_addr1 !== 32'hFFFF_FFF8) $display("FAIL async_reset_addr: got %h expected fffffff8", imem_addr1);
        else pass_cnt++;
        total_cnt++;
        if (dec_pc1 !== 32'h0) $display("FAIL async_reset_dec_pc: got %h expected 00000000", dec_pc1);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt        = 0;
        total_cnt       = 0;
        rst0            = 1'b0;
        rst1            = 1'b0;
        redirect_valid0 = 1'b0;
        redirect_pc0    = 32'h0;
        dec_ready0      = 1'b0;
        redirect_valid1 = 1'b0;
        redirect_pc1    = 32'h0;
        dec_ready1      = 1'b0;

        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_redirect();
        test_misaligned();
        test_wrap_and_async_reset();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
